dcache_data_array: RTL
======================

Name: dcache_data_array

Overview:
- Multi-way data array for the L1 data cache; generalises the single SDP cache data memory to NUM_WAYS ways with word-granular addressing, byte-masked stores and a line-refill write sequencer.
- One simple-dual-port synchronous RAM per way: a shared write port is arbitrated between the store path and the refill path, and a read port returns the addressed word from all ways in parallel so the tag logic can select the hit way.
- Same-cycle read/write collisions are forwarded, giving write-first semantics independent of the RAM primitive. Optional output register.

Parameters:
- NUM_WAYS, 2, number of ways (1..8)
- LINE_NUM, 64, sets per way
- WORD_NUM, 16, 32-bit-class words per line (power of 2)
- WORD_SIZE, 32, bits per word (multiple of 8)
- OUT_REG, 1, 0 = read data after 1 cycle, 1 = extra output register stage
- Derived:
  - SET_W = $clog2(LINE_NUM)
  - WOFF_W = $clog2(WORD_NUM)
  - WAY_W = max(1, $clog2(NUM_WAYS))
  - BE_W = WORD_SIZE/8

Ports:
- clk  in  1  common clock
- rst  in  1  synchronous reset, active-high
- st_valid  in  1  store write request
- st_ready  out  1  store accepted when st_valid & st_ready
- st_way  in  WAY_W  store target way
- st_set  in  SET_W  store set index
- st_word  in  WOFF_W  word offset in line
- st_be  in  BE_W  byte enables
- st_data  in  WORD_SIZE  store data
- fill_start  in  1  begin line refill (accepted only when fill_busy=0)
- fill_way  in  WAY_W  refill target way, sampled at start
- fill_set  in  SET_W  refill set, sampled at start
- fill_valid  in  1  refill data beat valid
- fill_data  in  WORD_SIZE  refill beat, words in ascending offset order
- fill_busy  out  1  refill in progress
- fill_done  out  1  one-cycle pulse after last beat is written
- rd_en  in  1  read request
- rd_set  in  SET_W  read set
- rd_word  in  WOFF_W  read word offset
- rd_valid  out  1  read data valid
- rd_data  out  NUM_WAYS*WORD_SIZE  word from every way; way i at bits [i*WORD_SIZE +: WORD_SIZE]

Behaviour:
- Reset values: st_ready=0 during rst then 1, fill_busy=0, fill_done=0, rd_valid=0, rd_data=0, beat counter=0. RAM contents are not cleared.
- Refill FSM states are IDLE and FILL.
  - IDLE -> FILL: on fill_start; latch way/set; counter=0; fill_busy=1 the next cycle.
  - In FILL, each fill_valid cycle writes fill_data with all bytes enabled to (way, set, counter), then counter+1.
  - The beat with counter=WORD_NUM-1 writes, then returns the FSM to IDLE. fill_done=1 and fill_busy=0 on the following cycle. The counter does not wrap into further writes.
  - fill_valid in IDLE is ignored. fill_start while busy is ignored.
- Store path: st_ready=1 in IDLE (outside reset), 0 throughout FILL.
  - An accepted store writes only the bytes with st_be set, in the same cycle.
  - st_be=0 is accepted and modifies nothing.
  - If st_valid and fill_start arrive in the same IDLE cycle, the store is accepted and written, and FILL starts the next cycle.
  - Only one writer per cycle, so there are no write-port conflicts.
- Read path: read issued in cycle T.
  - OUT_REG=0: rd_valid/rd_data in T+1.
  - OUT_REG=1: rd_valid/rd_data in T+2.
  - Back-to-back reads are fully pipelined, one per cycle.
  - rd_valid=0 in cycles without a corresponding read.
  - rd_data holds its last value when rd_valid=0.
- Collision forwarding: a write (store or fill) in cycle T to the same set/word as a read in T makes that way's returned word equal to the new bytes merged with the old unmasked bytes. Other ways are unaffected.
- A write in T+1 or later does not alter data for a read issued in T.
- Reset mid-refill: FSM to IDLE, no fill_done, pending rd_valid cleared. Partially written line contents are unspecified; the owner must re-fill.
- Address widths are exact. Out-of-range set/way when the parameter is not a power of 2 is illegal; add a simulation assertion.

Test Plan:
- Refill way 1, set 5, with 16 beats of 0x1000+i, inserting fill_valid gaps after beats 3 and 9 -> fill_done pulses exactly once, one cycle after beat 15. Reads of set 5, words 0..15 return way1 = 0x1000+i and leave way 0 unchanged.
- Store st_be=4'b0101, data 0xAABBCCDD to way 0/set 5/word 2 over old 0x11223344 -> read returns 0x11BB33DD in way 0. Latency 2 with OUT_REG=1, 1 with OUT_REG=0.
- Same-cycle store 0xDEADBEEF (be=1111) and read of that address -> returned word is 0xDEADBEEF, not stale. A store in the following cycle leaves that read's data unchanged.
- fill_start and st_valid in the same cycle -> store written, st_ready=0 for the next 16+ cycles, a store attempted mid-fill is not written, and st_ready returns to 1 with fill_done.
- rst asserted after beat 7 of a refill -> fill_busy=0 and rd_valid=0 the next cycle, no fill_done. A new refill then completes normally with 16 beats.
- 20 back-to-back reads across sets, with NUM_WAYS=4 and LINE_NUM=128 builds -> 20 consecutive rd_valid cycles, in-order data, correct way slicing.

Source files
------------

// File: rtl/dcache_data_array.sv
// L1 data-cache data array: one SDP RAM per way, shared byte-masked write port
// (store path or line-refill sequencer), parallel all-way read with write-first forwarding.
module dcache_data_array #(
   parameter int NUM_WAYS  = 2,
   parameter int LINE_NUM  = 64,
   parameter int WORD_NUM  = 16,
   parameter int WORD_SIZE = 32,
   parameter int OUT_REG   = 1,
   localparam int SET_W  = $clog2(LINE_NUM),
   localparam int WOFF_W = $clog2(WORD_NUM),
   localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
   localparam int BE_W   = WORD_SIZE / 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          st_valid,
   output logic                          st_ready,
   input  logic [WAY_W-1:0]              st_way,
   input  logic [SET_W-1:0]              st_set,
   input  logic [WOFF_W-1:0]             st_word,
   input  logic [BE_W-1:0]               st_be,
   input  logic [WORD_SIZE-1:0]          st_data,
   input  logic                          fill_start,
   input  logic [WAY_W-1:0]              fill_way,
   input  logic [SET_W-1:0]              fill_set,
   input  logic                          fill_valid,
   input  logic [WORD_SIZE-1:0]          fill_data,
   output logic                          fill_busy,
   output logic                          fill_done,
   input  logic                          rd_en,
   input  logic [SET_W-1:0]              rd_set,
   input  logic [WOFF_W-1:0]             rd_word,
   output logic                          rd_valid,
   output logic [NUM_WAYS*WORD_SIZE-1:0] rd_data
);
   localparam int ADDR_W = SET_W + WOFF_W;
   localparam int DEPTH  = LINE_NUM * WORD_NUM;
   localparam logic [WOFF_W-1:0] LAST_WORD = WOFF_W'(WORD_NUM - 1);
   localparam logic [SET_W:0]    SET_LIM   = (SET_W + 1)'(LINE_NUM);
   localparam logic [WAY_W:0]    WAY_LIM   = (WAY_W + 1)'(NUM_WAYS);

   typedef enum logic {IDLE, FILL} state_t;

   state_t             state_reg;
   logic [WAY_W-1:0]   fill_way_reg;
   logic [SET_W-1:0]   fill_set_reg;
   logic [WOFF_W-1:0]  beat_reg;
   logic               fill_busy_reg;
   logic               fill_done_reg;
   logic               valid1_reg;

   logic               st_fire;
   logic               fill_fire;
   logic               wr_en;
   logic [WAY_W-1:0]   wr_way;
   logic [ADDR_W-1:0]  wr_addr;
   logic [BE_W-1:0]    wr_be;
   logic [WORD_SIZE-1:0] wr_data;
   logic [ADDR_W-1:0]  rd_addr;

   assign st_ready  = !rst && (state_reg == IDLE);
   assign st_fire   = st_valid && st_ready;
   assign fill_fire = !rst && (state_reg == FILL) && fill_valid;
   assign fill_busy = fill_busy_reg;
   assign fill_done = fill_done_reg;
   assign rd_addr   = {rd_set, rd_word};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         fill_way_reg  <= '0;
         fill_set_reg  <= '0;
         beat_reg      <= '0;
         fill_busy_reg <= 1'b0;
         fill_done_reg <= 1'b0;
      end else begin
         fill_done_reg <= 1'b0;
         case (state_reg)
            IDLE: if (fill_start) begin
               state_reg     <= FILL;
               fill_busy_reg <= 1'b1;
               fill_way_reg  <= fill_way;
               fill_set_reg  <= fill_set;
               beat_reg      <= '0;
            end
            FILL: if (fill_valid) begin
               beat_reg <= beat_reg + 1'b1;
               if (beat_reg == LAST_WORD) begin
                  state_reg     <= IDLE;
                  fill_busy_reg <= 1'b0;
                  fill_done_reg <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Store and refill never overlap: st_ready is low for the whole FILL state.
   always_comb begin
      wr_en   = st_fire || fill_fire;
      wr_way  = st_way;
      wr_addr = {st_set, st_word};
      wr_be   = st_be;
      wr_data = st_data;
      if (fill_fire) begin
         wr_way  = fill_way_reg;
         wr_addr = {fill_set_reg, beat_reg};
         wr_be   = '1;
         wr_data = fill_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) valid1_reg <= 1'b0;
      else     valid1_reg <= rd_en;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
         logic [WORD_SIZE-1:0] mem [DEPTH];
         logic [WORD_SIZE-1:0] q_reg;
         logic [WORD_SIZE-1:0] fwd_data_reg;
         logic [BE_W-1:0]      fwd_be_reg;
         logic [WORD_SIZE-1:0] merged;
         logic                 way_we;

         assign way_we = wr_en && (wr_way == WAY_W'(gi));

         always_ff @(posedge clk) begin
            if (way_we) begin
               for (int b = 0; b < BE_W; b++) begin
                  if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
               end
            end
         end

         // RAM returns the old word on a collision; the captured write bytes patch it.
         always_ff @(posedge clk) begin
            if (rst) begin
               q_reg        <= '0;
               fwd_data_reg <= '0;
               fwd_be_reg   <= '0;
            end else if (rd_en) begin
               q_reg        <= mem[rd_addr];
               fwd_data_reg <= wr_data;
               fwd_be_reg   <= (way_we && (wr_addr == rd_addr)) ? wr_be : '0;
            end
         end

         always_comb begin
            merged = q_reg;
            for (int b = 0; b < BE_W; b++) begin
               if (fwd_be_reg[b]) merged[b*8 +: 8] = fwd_data_reg[b*8 +: 8];
            end
         end

         if (OUT_REG != 0) begin : g_oreg
            logic [WORD_SIZE-1:0] out_reg;
            always_ff @(posedge clk) begin
               if (rst)             out_reg <= '0;
               else if (valid1_reg) out_reg <= merged;
            end
            assign rd_data[gi*WORD_SIZE +: WORD_SIZE] = out_reg;
         end else begin : g_nreg
            assign rd_data[gi*WORD_SIZE +: WORD_SIZE] = merged;
         end
      end

      if (OUT_REG != 0) begin : g_vreg
         logic valid2_reg;
         always_ff @(posedge clk) begin
            if (rst) valid2_reg <= 1'b0;
            else     valid2_reg <= valid1_reg;
         end
         assign rd_valid = valid2_reg;
      end else begin : g_vnreg
         assign rd_valid = valid1_reg;
      end
   endgenerate

   a_st_addr: assert property (@(posedge clk) disable iff (rst)
      st_fire |-> (({1'b0, st_set} < SET_LIM) && ({1'b0, st_way} < WAY_LIM)));
   a_fill_addr: assert property (@(posedge clk) disable iff (rst)
      (fill_start && state_reg == IDLE) |-> (({1'b0, fill_set} < SET_LIM) && ({1'b0, fill_way} < WAY_LIM)));
   a_rd_addr: assert property (@(posedge clk) disable iff (rst)
      rd_en |-> ({1'b0, rd_set} < SET_LIM));
endmodule
